// File: rtl/ln1p_series_unit.sv
// Iterative Maclaurin-series ln(1+x): Q0.16 x in, Q2.16 result out, one shared 16x16 multiplier.
// Define LN1P_ROUND_EN to round both multiplies half-up instead of truncating.
module ln1p_series_unit #(
  parameter int NTERMS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] x_in,
  output logic [17:0] result,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    TERM  = 3'd2,
    ACCUM = 3'd3,
    POW   = 3'd4,
    DONE  = 3'd5
  } state_t;

`ifdef LN1P_ROUND_EN
  localparam logic [31:0] RND = 32'h0000_8000;
`else
  localparam logic [31:0] RND = 32'h0000_0000;
`endif

  localparam logic [2:0] KLAST = 3'(NTERMS - 1);

  state_t             state;
  logic [15:0]        xr, p, t;
  logic signed [17:0] acc;
  logic [2:0]         k;

  logic [15:0]        recip, mulB, mulHi;
  logic [17:0]        sum;
  logic [18:0]        diff;

  // 1/(k+1) in Q0.16; entry 0 saturates to FFFF standing in for 1.0
  always_comb begin
    recip = 16'hFFFF;
    case (k)
      3'd0: recip = 16'hFFFF;
      3'd1: recip = 16'h8000;
      3'd2: recip = 16'h5555;
      3'd3: recip = 16'h4000;
      3'd4: recip = 16'h3333;
      3'd5: recip = 16'h2AAB;
      3'd6: recip = 16'h2492;
      3'd7: recip = 16'h2000;
      default: recip = 16'hFFFF;
    endcase
  end

  // POW uses the multiplier for p*x, TERM for p*(1/(k+1))
  assign mulB  = (state == POW) ? xr : recip;
  assign mulHi = 16'((({16'h0000, p} * {16'h0000, mulB}) + RND) >> 16);

  assign sum  = acc + {2'b00, t};
  assign diff = {acc[17], acc} - {3'b000, t};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      xr    <= '0;
      p     <= '0;
      t     <= '0;
      acc   <= '0;
      k     <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: begin
          xr    <= x_in;
          p     <= x_in;
          acc   <= '0;
          k     <= '0;
          state <= TERM;
        end
        TERM: begin
          t     <= mulHi;
          state <= ACCUM;
        end
        ACCUM: begin
          if (!k[0])        acc <= sum;
          else if (diff[18]) acc <= '0;
          else              acc <= diff[17:0];
          if (k == KLAST) state <= DONE;
          else begin
            k     <= k + 3'd1;
            state <= POW;
          end
        end
        POW: begin
          p     <= mulHi;
          state <= TERM;
        end
        DONE: if (!start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign result = acc;
  assign done   = (state == DONE);

endmodule

// File: tb/tb_ln1p_series_unit.sv
// Directed bench for ln1p_series_unit: latency, values, handshake, abort and x_in isolation.
module tb_ln1p_series_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] xIn;
  logic [17:0] result, result1;
  logic        done, done1;

  int checks = 0;
  int errors = 0;

`ifdef LN1P_ROUND_EN
  localparam logic [17:0] EXP_HALF = 18'h067C3;
  localparam logic [17:0] EXP_ONE  = 18'h08000;
`else
  localparam logic [17:0] EXP_HALF = 18'h067C1;
  localparam logic [17:0] EXP_ONE  = 18'h07FFF;
`endif

  ln1p_series_unit #(.NTERMS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(xIn), .result(result), .done(done)
  );

  ln1p_series_unit #(.NTERMS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .x_in(xIn), .result(result1), .done(done1)
  );

  always #5 clk = ~clk;

  task automatic dropStart();
    @(negedge clk);
    start = 1'b0;
  endtask

  // start at a negedge so the next posedge is edge 1; done must rise exactly after edge 25
  task automatic runConv(input logic [15:0] x, input logic [17:0] expRes, input string name);
    @(negedge clk);
    xIn   = x;
    start = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL %s_early: done=%b required 0 after edge 24", name, done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s_done: done=%b required 1 after edge 25", name, done);
    end
    checks++;
    if (result !== expRes) begin
      errors++; $display("FAIL %s_result: result=%h required %h", name, result, expRes);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    xIn   = 16'h0000;
    #12;
    checks++;
    if (result !== 18'h0 || done !== 1'b0) begin
      errors++; $display("FAIL reset: result=%h done=%b required 0 0", result, done);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL reset_idle: done=%b done1=%b required 0 0", done, done1);
    end
  endtask

  task automatic test_zero();
    runConv(16'h0000, 18'h00000, "zero");
    dropStart();
  endtask

  task automatic test_half();
    runConv(16'h8000, EXP_HALF, "half");
    dropStart();
  endtask

  task automatic test_nterms1();
    @(negedge clk);
    xIn   = 16'h8000;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b0) begin
      errors++; $display("FAIL n1_early: done1=%b required 0 after edge 3", done1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done1 !== 1'b1 || result1 !== EXP_ONE) begin
      errors++; $display("FAIL n1_result: done1=%b result1=%h required 1 %h", done1, result1, EXP_ONE);
    end
    repeat (21) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || result !== EXP_HALF) begin
      errors++; $display("FAIL n1_main: done=%b result=%h required 1 %h", done, result, EXP_HALF);
    end
    dropStart();
  endtask

  task automatic test_hold();
    runConv(16'h8000, EXP_HALF, "hold");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || result !== EXP_HALF) begin
        errors++; $display("FAIL hold_stay%0d: done=%b result=%h required 1 %h", i, done, result, EXP_HALF);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL hold_release: done=%b required 0", done);
    end
    runConv(16'h0000, 18'h00000, "hold_next");
    dropStart();
  endtask

  task automatic test_abort();
    @(negedge clk);
    xIn   = 16'h8000;
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (result !== 18'h0 || done !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL abort: result=%h done=%b done1=%b required 0 0 0", result, done, done1);
    end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    runConv(16'h8000, EXP_HALF, "abort_restart");
    dropStart();
  endtask

  task automatic test_xin_change();
    @(negedge clk);
    xIn   = 16'h8000;
    start = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (i == 24) begin
        checks++;
        if (done !== 1'b0) begin
          errors++; $display("FAIL xchg_early: done=%b required 0", done);
        end
      end
      if (i == 25) begin
        checks++;
        if (done !== 1'b1 || result !== EXP_HALF) begin
          errors++; $display("FAIL xchg_result: done=%b result=%h required 1 %h", done, result, EXP_HALF);
        end
      end
      if (i >= 2) xIn = 16'($urandom);
    end
    dropStart();
  endtask

  // start released early: conversion still completes and DONE lasts one cycle
  task automatic test_start_drop();
    @(negedge clk);
    xIn   = 16'h8000;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (22) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || result !== EXP_HALF) begin
      errors++; $display("FAIL drop_done: done=%b result=%h required 1 %h", done, result, EXP_HALF);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL drop_pulse: done=%b required 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_half();
    test_nterms1();
    test_hold();
    test_abort();
    test_xin_change();
    test_start_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
